// File: rtl/bpm_position_calc.sv
// bpm_position_calc
//   Normalised beam position from four button peak amplitudes:
//     X = ((A+D)-(B+C))/S,  Y = ((A+B)-(C+D))/S,  S = A+B+C+D
//   One restoring divider is shared, computing X and then Y. Results are
//   signed Q1.15, with low-signal, ADC-overflow and dropped-frame flags.
//
//   Optional feature macro: BPM_POS_AVG_EN
//     When defined, exponential moving averages of the positions are
//     provided on pos_x_avg / pos_y_avg (weight 2^-AVG_SHIFT).
//
//   Handshake: peak_valid is a single-cycle strobe accepted only in IDLE.
//   Any strobe seen while a frame is in flight (including the DONE cycle)
//   is discarded and remembered in a sticky drop bit. pos_valid is a
//   single-cycle strobe and all result outputs hold between strobes.
//   There is no backpressure on the output side.
//
//   state_dbg exposes the FSM state:
//   0=IDLE 1=LOAD 2=DIV_X 3=DIV_Y 4=DONE.

module bpm_position_calc #(
  parameter int FRAC_BITS = 15,
  parameter int MIN_SUM   = 64,
  parameter int AVG_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        peak_valid,
  input  logic [15:0] max_a,
  input  logic [15:0] max_b,
  input  logic [15:0] max_c,
  input  logic [15:0] max_d,
  input  logic        over_flow_a,
  input  logic        over_flow_b,
  input  logic        over_flow_c,
  input  logic        over_flow_d,
  output logic        busy,
  output logic        pos_valid,
  output logic [15:0] pos_x,
  output logic [15:0] pos_y,
  output logic [16:0] sum_abcd,
  output logic        flag_low,
  output logic        flag_ovf,
  output logic        flag_drop,
`ifdef BPM_POS_AVG_EN
  output logic [15:0] pos_x_avg,
  output logic [15:0] pos_y_avg,
`endif
  output logic [2:0]  state_dbg
);

  // Divider iterations: one quotient bit per cycle, including the integer bit.
  localparam int              N         = FRAC_BITS + 1;
  localparam int              CNT_W     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [16:0]     MIN_SUM_W = 17'(MIN_SUM);
  // Only the 15 LSBs of each peak carry amplitude; bit 15 is forced to 0.
  localparam logic [15:0]     PEAK_MASK = 16'h7FFF;
  localparam logic [15:0]     Q_SAT     = 16'((1 << FRAC_BITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DIV_X = 3'd2,
    S_DIV_Y = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  // Captured frame
  logic [15:0] cap_a, cap_b, cap_c, cap_d;
  logic        cap_ovf;

  // Values registered in LOAD
  logic [16:0]        sum_r;
  logic signed [17:0] nx_r, ny_r;
  logic               low_r;

  // Divider state
  logic [CNT_W-1:0] cnt;
  logic [16:0]      rem;
  logic [N-2:0]     quo;
  logic [15:0]      x_res, y_res;

  logic drop_sticky;

  // Combinational LOAD arithmetic
  logic [16:0]        sum_w;
  logic signed [17:0] nx_w, ny_w;

  // Combinational divider step
  logic signed [17:0] n_sel;
  logic               n_neg;
  logic [17:0]        n_abs;
  logic [17:0]        trial;
  logic               ge;
  logic [N-1:0]       q_full;
  logic [15:0]        q_mag;
  logic [15:0]        q_signed;

  assign state_dbg = state;
  assign busy      = (state != S_IDLE);

  // Sum and difference terms of the captured amplitudes.
  always_comb begin
    sum_w = 17'(cap_a) + 17'(cap_b) + 17'(cap_c) + 17'(cap_d);
    nx_w  = 18'(cap_a) + 18'(cap_d) - 18'(cap_b) - 18'(cap_c);
    ny_w  = 18'(cap_a) + 18'(cap_b) - 18'(cap_c) - 18'(cap_d);
  end

  // One restoring-division step on |n|<<FRAC_BITS. The first step compares
  // |n| itself (the integer bit); later steps shift the remainder left.
  always_comb begin
    n_sel    = (state == S_DIV_Y) ? ny_r : nx_r;
    n_neg    = n_sel[17];
    n_abs    = n_neg ? 18'(-n_sel) : 18'(n_sel);
    trial    = (cnt == '0) ? n_abs : {rem, 1'b0};
    ge       = (trial >= {1'b0, sum_r});
    q_full   = {quo, ge};
    // |n| == S is the only way to reach the integer bit; clamp to just below 1.0
    q_mag    = q_full[FRAC_BITS] ? Q_SAT : 16'(q_full);
    q_signed = n_neg ? (~q_mag + 16'd1) : q_mag;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (peak_valid) state_next = S_LOAD;
      S_LOAD:  state_next = (sum_w < MIN_SUM_W) ? S_DONE : S_DIV_X;
      S_DIV_X: if (cnt == LAST_CNT) state_next = S_DIV_Y;
      S_DIV_Y: if (cnt == LAST_CNT) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Capture, LOAD registers and the shared divider datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_a   <= '0;
      cap_b   <= '0;
      cap_c   <= '0;
      cap_d   <= '0;
      cap_ovf <= 1'b0;
      sum_r   <= '0;
      nx_r    <= '0;
      ny_r    <= '0;
      low_r   <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      x_res   <= '0;
      y_res   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (peak_valid) begin
            cap_a   <= max_a & PEAK_MASK;
            cap_b   <= max_b & PEAK_MASK;
            cap_c   <= max_c & PEAK_MASK;
            cap_d   <= max_d & PEAK_MASK;
            cap_ovf <= over_flow_a | over_flow_b | over_flow_c | over_flow_d;
          end
        end
        S_LOAD: begin
          sum_r <= sum_w;
          nx_r  <= nx_w;
          ny_r  <= ny_w;
          low_r <= (sum_w < MIN_SUM_W);
          cnt   <= '0;
        end
        S_DIV_X, S_DIV_Y: begin
          rem <= ge ? 17'(trial - {1'b0, sum_r}) : trial[16:0];
          quo <= q_full[N-2:0];
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (state == S_DIV_X) x_res <= q_signed;
            else                  y_res <= q_signed;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky record of strobes ignored since the last report.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 drop_sticky <= 1'b0;
    else if (state == S_DONE)                 drop_sticky <= 1'b0;
    else if (peak_valid && state != S_IDLE)   drop_sticky <= 1'b1;
  end

  // Result registers, updated once per frame on leaving DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_valid <= 1'b0;
      pos_x     <= '0;
      pos_y     <= '0;
      sum_abcd  <= '0;
      flag_low  <= 1'b0;
      flag_ovf  <= 1'b0;
      flag_drop <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      if (state == S_DONE) begin
        pos_valid <= 1'b1;
        pos_x     <= low_r ? 16'd0 : x_res;
        pos_y     <= low_r ? 16'd0 : y_res;
        sum_abcd  <= sum_r;
        flag_low  <= low_r;
        flag_ovf  <= cap_ovf;
        // A strobe landing in the DONE cycle belongs to this report.
        flag_drop <= drop_sticky | peak_valid;
      end
    end
  end

`ifdef BPM_POS_AVG_EN
  logic [15:0] avg_x, avg_y;
  logic        avg_init;

  // avg + ((pos - avg) >>> AVG_SHIFT) at 18 bits, clamped back to Q1.15.
  function automatic logic [15:0] ema_step(input logic [15:0] avg,
                                           input logic [15:0] pos);
    logic signed [17:0] a18, p18, d18, u18;
    a18 = {{2{avg[15]}}, avg};
    p18 = {{2{pos[15]}}, pos};
    d18 = p18 - a18;
    u18 = a18 + (d18 >>> AVG_SHIFT);
    if (u18 > 18'sd32767)       ema_step = 16'h7FFF;
    else if (u18 < -18'sd32768) ema_step = 16'h8000;
    else                        ema_step = u18[15:0];
  endfunction

  assign pos_x_avg = avg_x;
  assign pos_y_avg = avg_y;

  // Moving average over non-low frames; the first such frame seeds it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avg_x    <= '0;
      avg_y    <= '0;
      avg_init <= 1'b0;
    end else if (state == S_DONE && !low_r) begin
      avg_init <= 1'b1;
      if (!avg_init) begin
        avg_x <= x_res;
        avg_y <= y_res;
      end else begin
        avg_x <= ema_step(avg_x, x_res);
        avg_y <= ema_step(avg_y, y_res);
      end
    end
  end
`endif

endmodule
